program_loader: RTL

Byte-stream boot loader that builds 32-bit instruction words from a serial link and writes them into instruction memory while holding the processor in reset. It checks every opcode field (IR[31:25]) against the legal opcode set, so no undecodable word reaches the instruction decoder. It verifies a framed length and an XOR checksum, then releases the pipeline on success.

---
 rtl/program_loader.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: serial boot loader. Assembles 32-bit instruction words
// from a framed byte stream and writes them to instruction memory. Every
// opcode is screened against the legal set, and the frame is checked for
// length and XOR checksum. The CPU stays held in reset until a frame
// completes cleanly.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_SYNC   | idle after reset, discard bytes until 0xA5
// S_LEN_HI | expecting high byte of the word count
// S_LEN_LO | expecting low byte of the word count, range-check it
// S_DATA   | collecting the 4 bytes of an instruction word
// S_WRITE  | one-cycle memory write strobe, rx_ready low (bubble)
// S_CSUM   | expecting the checksum byte
// S_DONE   | load succeeded, CPU released, wait for 0xA5 to reload
// S_ERROR  | load aborted, CPU held, wait for 0xA5 to reload
module program_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_OP   = 2'd2;
    localparam logic [1:0] ERR_CSUM = 2'd3;

    state_t state, state_nxt;

    logic [7:0]      len_hi;
    logic [ADDR_W:0] len_words;
    logic [1:0]      byte_idx;
    logic [23:0]     hold;
    logic [7:0]      csum;

    logic        byte_fire;
    logic [15:0] len_full;
    logic        len_bad;
    logic [31:0] word_full;
    logic        op_legal;
    logic        last_word;

    logic restart;
    logic hi_take;
    logic len_load;
    logic len_err;
    logic data_take;
    logic word_good;
    logic word_bad;
    logic csum_pass;
    logic csum_fail;

    // Opcode screen on IR[31:25]; anything not listed is undecodable.
    function automatic logic legal_op(input logic [6:0] op);
        logic ok;
        ok = 1'b0;
        case (op)
            7'h00, 7'h40, 7'h02, 7'h05, 7'h08, 7'h09, 7'h0A, 7'h0B,
            7'h22, 7'h25, 7'h28, 7'h29, 7'h2A, 7'h42, 7'h45, 7'h0C,
            7'h0D, 7'h0E, 7'h10, 7'h20, 7'h70, 7'h65, 7'h60, 7'h48,
            7'h68, 7'h30: ok = 1'b1;
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // The only bubble is the write cycle, which keeps the word path simple.
    assign rx_ready  = (state != S_WRITE);
    assign byte_fire = rx_valid && rx_ready;

    assign len_full  = {len_hi, rx_data};
    assign len_bad   = (len_full == 16'd0) || (32'(len_full) > MAX_WORDS);
    assign word_full = {hold, rx_data};
    assign op_legal  = legal_op(word_full[31:25]);
    // word_count has already been bumped by the time WRITE is evaluated.
    assign last_word = (word_count == len_words);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-byte action strobes.
    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        hi_take   = 1'b0;
        len_load  = 1'b0;
        len_err   = 1'b0;
        data_take = 1'b0;
        word_good = 1'b0;
        word_bad  = 1'b0;
        csum_pass = 1'b0;
        csum_fail = 1'b0;
        case (state)
            S_SYNC, S_DONE, S_ERROR: begin
                if (byte_fire && (rx_data == SYNC_BYTE)) begin
                    restart   = 1'b1;
                    state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (byte_fire) begin
                    hi_take   = 1'b1;
                    state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (byte_fire) begin
                    if (len_bad) begin
                        len_err   = 1'b1;
                        state_nxt = S_ERROR;
                    end else begin
                        len_load  = 1'b1;
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (byte_fire) begin
                    if (byte_idx != 2'd3) begin
                        data_take = 1'b1;
                    end else if (op_legal) begin
                        word_good = 1'b1;
                        state_nxt = S_WRITE;
                    end else begin
                        word_bad  = 1'b1;
                        state_nxt = S_ERROR;
                    end
                end
            end
            S_WRITE: begin
                state_nxt = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (byte_fire) begin
                    if (rx_data == csum) begin
                        csum_pass = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        csum_fail = 1'b1;
                        state_nxt = S_ERROR;
                    end
                end
            end
            default: begin
                state_nxt = S_SYNC;
            end
        endcase
    end

    // Frame datapath: length, byte assembly and running checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_hi    <= 8'd0;
            len_words <= '0;
            byte_idx  <= 2'd0;
            hold      <= 24'd0;
            csum      <= 8'd0;
        end else begin
            if (restart) begin
                byte_idx <= 2'd0;
                csum     <= 8'd0;
            end else if (hi_take || len_load || data_take || word_good) begin
                csum <= csum ^ rx_data;
            end
            if (hi_take) begin
                len_hi <= rx_data;
            end
            if (len_load) begin
                len_words <= len_full[ADDR_W:0];
            end
            if (data_take) begin
                hold     <= {hold[15:0], rx_data};
                byte_idx <= byte_idx + 2'd1;
            end else if (word_good) begin
                byte_idx <= 2'd0;
            end
        end
    end

    // Memory write port; address and data hold until the next write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            word_count <= '0;
        end else begin
            imem_we <= word_good;
            if (restart) begin
                word_count <= '0;
            end else if (word_good) begin
                imem_addr  <= word_count[ADDR_W-1:0];
                imem_wdata <= word_full;
                word_count <= word_count + 1'b1;
            end
        end
    end

    // Load status and CPU hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold  <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            err_code  <= ERR_NONE;
        end else begin
            if (restart) begin
                cpu_hold  <= 1'b1;
                load_done <= 1'b0;
                load_err  <= 1'b0;
                err_code  <= ERR_NONE;
            end else if (csum_pass) begin
                cpu_hold  <= 1'b0;
                load_done <= 1'b1;
            end else if (len_err) begin
                load_err <= 1'b1;
                err_code <= ERR_LEN;
            end else if (word_bad) begin
                load_err <= 1'b1;
                err_code <= ERR_OP;
            end else if (csum_fail) begin
                load_err <= 1'b1;
                err_code <= ERR_CSUM;
            end
        end
    end

endmodule
